// File: rtl/bomberman_move.sv
// bomberman_move: player movement controller.
// Converts debounced direction buttons into the player's top-left pixel
// position, one pixel per movement tick, refusing steps into blocked
// directions or past the arena bounds. Also drives facing direction and
// walk-animation state for the sprite ROM.
// Optional feature macro: BM_GRID_SNAP_EN (keep stepping to the 16-pixel
// grid after the buttons are released).
module bomberman_move #(
   parameter int unsigned MOVE_DIV   = 400000,
   parameter int unsigned SETTLE_CYC = 3,
   parameter int unsigned ANIM_STEPS = 4,
   parameter int unsigned X_MIN      = 159,
   parameter int unsigned X_MAX      = 463,
   parameter int unsigned Y_MIN      = 49,
   parameter int unsigned Y_MAX      = 417,
   parameter int unsigned X_INIT     = 159,
   parameter int unsigned Y_INIT     = 49
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic [3:0] bomberman_blocked,
   output logic [9:0] b_x,
   output logic [9:0] b_y,
   output logic [1:0] facing,
   output logic       walking,
   output logic [1:0] walk_frame
);

   localparam int unsigned DIV_W  = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
   localparam int unsigned SET_W  = $clog2(SETTLE_CYC + 1);
   localparam int unsigned STEP_W = $clog2(ANIM_STEPS + 1);

   localparam logic [9:0] XMIN = 10'(X_MIN);
   localparam logic [9:0] XMAX = 10'(X_MAX);
   localparam logic [9:0] YMIN = 10'(Y_MIN);
   localparam logic [9:0] YMAX = 10'(Y_MAX);

   // FSM encodings
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] CHECK  = 2'd1;
   localparam logic [1:0] SETTLE = 2'd2;

   // direction encodings (shared with facing)
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   logic [1:0]        state;
   logic [DIV_W-1:0]  div_cnt;
   logic [SET_W-1:0]  settle_cnt;
   logic [STEP_W-1:0] step_cnt;
   logic [1:0]        dir;
   logic              tick;
   logic              req_valid;
   logic [1:0]        req_dir;
   logic              refuse;

`ifdef BM_GRID_SNAP_EN
   logic       snap_hold;
   logic [9:0] dx;
   logic [9:0] dy;
   logic       off_grid;

   // position relative to the arena origin decides grid alignment
   always_comb begin
      dx       = b_x - XMIN;
      dy       = b_y - YMIN;
      off_grid = (dx[3:0] != 4'd0) || (dy[3:0] != 4'd0);
   end
`endif

   assign tick = (div_cnt == DIV_W'(MOVE_DIV - 1));

   // priority request encoder: up > down > left > right
   always_comb begin
      req_valid = btn_up | btn_down | btn_left | btn_right;
      req_dir   = DIR_RIGHT;
      if (btn_up)
         req_dir = DIR_UP;
      else if (btn_down)
         req_dir = DIR_DOWN;
      else if (btn_left)
         req_dir = DIR_LEFT;
   end

   // refusal: blocked[3-dir] set, or already on the bound in that direction
   always_comb begin
      refuse = 1'b0;
      case (dir)
         DIR_UP:    refuse = bomberman_blocked[3] || (b_y == YMIN);
         DIR_DOWN:  refuse = bomberman_blocked[2] || (b_y == YMAX);
         DIR_LEFT:  refuse = bomberman_blocked[1] || (b_x == XMIN);
         default:   refuse = bomberman_blocked[0] || (b_x == XMAX);
      endcase
   end

   // divider, movement FSM, position and animation state
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         div_cnt    <= '0;
         settle_cnt <= '0;
         step_cnt   <= '0;
         dir        <= DIR_DOWN;
         b_x        <= 10'(X_INIT);
         b_y        <= 10'(Y_INIT);
         facing     <= DIR_DOWN;
         walking    <= 1'b0;
         walk_frame <= '0;
`ifdef BM_GRID_SNAP_EN
         snap_hold  <= 1'b0;
`endif
      end else begin
         div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);

         case (state)
            IDLE: begin
               if (tick) begin
                  if (req_valid) begin
                     dir     <= req_dir;
                     facing  <= req_dir;
                     walking <= 1'b1;
                     state   <= CHECK;
`ifdef BM_GRID_SNAP_EN
                     snap_hold <= 1'b0;
`endif
                  end
`ifdef BM_GRID_SNAP_EN
                  else if (off_grid && !snap_hold) begin
                     walking <= 1'b1;
                     state   <= CHECK;
                  end
`endif
                  else begin
                     walking    <= 1'b0;
                     walk_frame <= '0;
                  end
               end
            end

            CHECK: begin
               if (refuse) begin
                  state <= IDLE;
`ifdef BM_GRID_SNAP_EN
                  snap_hold <= 1'b1;
`endif
               end else begin
                  case (dir)
                     DIR_UP:    b_y <= b_y - 10'd1;
                     DIR_DOWN:  b_y <= b_y + 10'd1;
                     DIR_LEFT:  b_x <= b_x - 10'd1;
                     default:   b_x <= b_x + 10'd1;
                  endcase
                  if (step_cnt == STEP_W'(ANIM_STEPS - 1)) begin
                     step_cnt   <= '0;
                     walk_frame <= walk_frame + 2'd1;
                  end else begin
                     step_cnt <= step_cnt + STEP_W'(1);
                  end
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end

            SETTLE: begin
               if (settle_cnt == SET_W'(SETTLE_CYC - 1))
                  state <= IDLE;
               else
                  settle_cnt <= settle_cnt + SET_W'(1);
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bomberman_move.sv
// tb_bomberman_move: directed bench for bomberman_move with MOVE_DIV=8.
// The divider phase is tracked by edge counting: after reset release the
// tick is sampled on edge 8k and the position updates on edge 8k+1.
module tb_bomberman_move;

   logic       clk;
   logic       reset;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic [3:0] bomberman_blocked;
   logic [9:0] b_x;
   logic [9:0] b_y;
   logic [1:0] facing;
   logic       walking;
   logic [1:0] walk_frame;

   int checks;
   int errors;

   bomberman_move #(
      .MOVE_DIV   (8),
      .SETTLE_CYC (3),
      .ANIM_STEPS (4)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .btn_up            (btn_up),
      .btn_down          (btn_down),
      .btn_left          (btn_left),
      .btn_right         (btn_right),
      .bomberman_blocked (bomberman_blocked),
      .b_x               (b_x),
      .b_y               (b_y),
      .facing            (facing),
      .walking           (walking),
      .walk_frame        (walk_frame)
   );

   // 10 ns clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic run_ticks(input int n);
      step_clk(8 * n);
   endtask

   task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
      btn_up    = u;
      btn_down  = d;
      btn_left  = l;
      btn_right = r;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b0;
      bomberman_blocked = 4'b0000;
      set_btn(0, 0, 0, 0);

      // reset values
      step_clk(2);
      check_eq("rst_x", b_x, 159);
      check_eq("rst_y", b_y, 49);
      check_eq("rst_facing", facing, 1);
      check_eq("rst_walking", walking, 0);
      check_eq("rst_frame", walk_frame, 0);

      // hold right: tick on edge 8, update on edge 9, then every 8 edges
      reset = 1'b1;
      set_btn(0, 0, 0, 1);
      step_clk(7);
      check_eq("pre_tick_x", b_x, 159);
      check_eq("pre_tick_walk", walking, 0);
      step_clk(1);
      check_eq("tick_edge_x", b_x, 159);
      check_eq("tick_edge_walk", walking, 1);
      check_eq("tick_edge_facing", facing, 3);
      step_clk(1);
      check_eq("first_step_x", b_x, 160);
      step_clk(7);
      check_eq("second_tick_x", b_x, 160);
      step_clk(1);
      check_eq("second_step_x", b_x, 161);
      run_ticks(8);
      check_eq("ten_steps_x", b_x, 169);
      check_eq("ten_steps_frame", walk_frame, 2);
      check_eq("ten_steps_y", b_y, 49);

      // move to (170,60)
      run_ticks(1);
      set_btn(0, 1, 0, 0);
      run_ticks(11);
      check_eq("pos_x_170", b_x, 170);
      check_eq("pos_y_60", b_y, 60);
      check_eq("down_facing", facing, 1);

      // up beats right
      set_btn(1, 0, 0, 1);
      run_ticks(1);
      check_eq("prio_facing", facing, 0);
      check_eq("prio_y", b_y, 59);
      check_eq("prio_x", b_x, 170);
      set_btn(0, 1, 0, 0);
      run_ticks(1);
      check_eq("back_y", b_y, 60);

      // blocked right
      bomberman_blocked = 4'b0001;
      set_btn(0, 0, 0, 1);
      run_ticks(2);
      check_eq("blk_facing", facing, 3);
      check_eq("blk_x", b_x, 170);
      check_eq("blk_walking", walking, 1);
      set_btn(0, 0, 0, 0);
      run_ticks(1);
      check_eq("blk_release_walk", walking, 0);
      check_eq("blk_release_frame", walk_frame, 0);
      bomberman_blocked = 4'b0000;

      // left bound
      set_btn(0, 0, 1, 0);
      run_ticks(14);
      check_eq("left_bound_x", b_x, 159);
      check_eq("left_facing", facing, 2);

      // bottom bound: 357 steps plus 3 refused
      set_btn(0, 1, 0, 0);
      run_ticks(360);
      check_eq("bottom_bound_y", b_y, 417);
      check_eq("bottom_x", b_x, 159);

      // reset during SETTLE
      set_btn(1, 0, 0, 0);
      run_ticks(1);
      check_eq("up_from_bottom", b_y, 416);
      reset = 1'b0;
      set_btn(0, 0, 0, 0);
      step_clk(1);
      check_eq("mid_rst_x", b_x, 159);
      check_eq("mid_rst_y", b_y, 49);
      check_eq("mid_rst_facing", facing, 1);
      check_eq("mid_rst_walking", walking, 0);
      check_eq("mid_rst_frame", walk_frame, 0);

      // release right at 164
      reset = 1'b1;
      set_btn(0, 0, 0, 1);
      step_clk(9);
      check_eq("restart_x", b_x, 160);
      run_ticks(4);
      check_eq("release_pt_x", b_x, 164);
      set_btn(0, 0, 0, 0);
      run_ticks(12);
`ifdef BM_GRID_SNAP_EN
      check_eq("snap_x", b_x, 175);
`else
      check_eq("nosnap_x", b_x, 164);
`endif
      check_eq("release_walk", walking, 0);
      check_eq("release_y", b_y, 49);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
